// File: rtl/svc_axi_pkg.sv
// Shared AXI definitions: burst/response encodings, read front-end FSM states
// and a helper for the byte-offset width of a data bus.
package svc_axi_pkg;

  // AXI burst type encodings (arburst/awburst)
  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  // AXI response encodings
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;

  // Read front-end control states
  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_BURST = 1'b1
  } rd_state_e;

  // Number of byte-offset bits inside one data word of dw bits
  function automatic int unsigned axi_lsb_bits(input int unsigned dw);
    return $clog2(dw) - 3;
  endfunction

endpackage

// File: rtl/svc_axi_sram_if_rd_burst_if.sv
// Bundle of the AXI read channels (AR, R) and the SRAM read command/response
// channels seen by svc_axi_sram_if_rd_burst.
//  slave  : the front end's view (AXI slave, SRAM requester)
//  master : the environment's view (AXI master, SRAM model)
interface svc_axi_sram_if_rd_burst_if #(
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int AXI_DATA_WIDTH = 16,
  parameter int AXI_ID_WIDTH   = 4
);
  import svc_axi_pkg::*;

  localparam int LSB = axi_lsb_bits(AXI_DATA_WIDTH);
  localparam int SAW = AXI_ADDR_WIDTH - LSB;
  localparam int MW  = AXI_ID_WIDTH + 1;

  // AXI AR channel
  logic                      s_axi_arvalid;
  logic                      s_axi_arready;
  logic [AXI_ID_WIDTH-1:0]   s_axi_arid;
  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr;
  logic [7:0]                s_axi_arlen;
  logic [2:0]                s_axi_arsize;
  logic [1:0]                s_axi_arburst;

  // AXI R channel
  logic                      s_axi_rvalid;
  logic                      s_axi_rready;
  logic [AXI_ID_WIDTH-1:0]   s_axi_rid;
  logic [AXI_DATA_WIDTH-1:0] s_axi_rdata;
  logic [1:0]                s_axi_rresp;
  logic                      s_axi_rlast;

  // SRAM read command channel
  logic                      sram_rd_cmd_valid;
  logic                      sram_rd_cmd_ready;
  logic [SAW-1:0]            sram_rd_cmd_addr;
  logic [MW-1:0]             sram_rd_cmd_meta;

  // SRAM read response channel
  logic                      sram_rd_resp_valid;
  logic                      sram_rd_resp_ready;
  logic [AXI_DATA_WIDTH-1:0] sram_rd_resp_data;
  logic [MW-1:0]             sram_rd_resp_meta;

  modport slave (
    input  s_axi_arvalid, s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
    output s_axi_arready,
    output s_axi_rvalid, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
    input  s_axi_rready,
    output sram_rd_cmd_valid, sram_rd_cmd_addr, sram_rd_cmd_meta,
    input  sram_rd_cmd_ready,
    input  sram_rd_resp_valid, sram_rd_resp_data, sram_rd_resp_meta,
    output sram_rd_resp_ready
  );

  modport master (
    output s_axi_arvalid, s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
    input  s_axi_arready,
    input  s_axi_rvalid, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
    output s_axi_rready,
    input  sram_rd_cmd_valid, sram_rd_cmd_addr, sram_rd_cmd_meta,
    output sram_rd_cmd_ready,
    output sram_rd_resp_valid, sram_rd_resp_data, sram_rd_resp_meta,
    input  sram_rd_resp_ready
  );

endinterface

// File: rtl/svc_axi_burst_addr.sv
// Combinational AXI next-beat byte address. Shared by read and write sides.
// FIXED keeps the address, INCR and the reserved encoding align down to the
// beat size and step by one beat. WRAP stepping is only built when
// SVC_AXI_SRAM_IF_RD_WRAP_EN is defined; otherwise WRAP steps like INCR.
// All arithmetic is AW bits wide, so the address wraps modulo 2^AW.
module svc_axi_burst_addr
  import svc_axi_pkg::*;
#(
  parameter int AW = 20
) (
  input  logic [AW-1:0] addr,
  input  logic [2:0]    size,
  input  logic [7:0]    len,
  input  logic [1:0]    burst,
  output logic [AW-1:0] next_addr
);

  logic [AW-1:0] beat_bytes;
  logic [AW-1:0] incr_addr;

  assign beat_bytes = AW'(1) << size;
  assign incr_addr  = (addr & ~(beat_bytes - AW'(1))) + beat_bytes;

`ifdef SVC_AXI_SRAM_IF_RD_WRAP_EN
  logic [AW-1:0] wrap_mask;
  logic [AW-1:0] wrap_addr;

  // Wrap window is the total burst length in bytes (a power of two for legal WRAP)
  assign wrap_mask = ((AW'(len) + AW'(1)) << size) - AW'(1);
  assign wrap_addr = (addr & ~wrap_mask) | ((addr + beat_bytes) & wrap_mask);

  // Select the step rule for the burst type
  always_comb begin
    next_addr = incr_addr;
    case (burst)
      AXI_BURST_FIXED: next_addr = addr;
      AXI_BURST_WRAP:  next_addr = wrap_addr;
      default:         next_addr = incr_addr;
    endcase
  end
`else
  // Burst length only matters for the wrap window
  logic unused_len;
  assign unused_len = ^len;

  // Select the step rule for the burst type; WRAP steps like INCR
  always_comb begin
    next_addr = incr_addr;
    case (burst)
      AXI_BURST_FIXED: next_addr = addr;
      default:         next_addr = incr_addr;
    endcase
  end
`endif

endmodule

// File: rtl/svc_axi_sram_if_rd_burst.sv
// AXI4 read-slave front end for a single-port SRAM.
// Accepts one AR burst at a time and issues one SRAM word read per beat,
// carrying {id, last} in the SRAM meta field so the R channel can be driven
// straight from the SRAM responses (which come back in command order).
// Narrow beats read the whole containing word; no lane steering is done.
// Optional feature macro: SVC_AXI_SRAM_IF_RD_WRAP_EN enables WRAP stepping
// (otherwise WRAP bursts step like INCR).
module svc_axi_sram_if_rd_burst
  import svc_axi_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int AXI_DATA_WIDTH = 16,
  parameter int AXI_ID_WIDTH   = 4
) (
  input logic                       clk,
  input logic                       rst_n,
  svc_axi_sram_if_rd_burst_if.slave bus
);

  localparam int AW  = AXI_ADDR_WIDTH;
  localparam int IW  = AXI_ID_WIDTH;
  localparam int LSB = axi_lsb_bits(AXI_DATA_WIDTH);
  localparam int MW  = IW + 1;

  rd_state_e     state_reg, state_next;
  logic          arready_reg, arready_next;
  logic          cmd_valid_reg, cmd_valid_next;
  logic [IW-1:0] id_reg, id_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [7:0]    len_reg, len_next;
  logic [2:0]    size_reg, size_next;
  logic [1:0]    burst_reg, burst_next;
  logic [7:0]    beats_left_reg, beats_left_next;
  logic [AW-1:0] step_addr;
  logic          ar_fire;
  logic          cmd_fire;
  logic          last_beat;

  assign ar_fire   = arready_reg && bus.s_axi_arvalid;
  assign cmd_fire  = cmd_valid_reg && bus.sram_rd_cmd_ready;
  assign last_beat = (beats_left_reg == 8'd0);

  svc_axi_burst_addr #(
    .AW(AW)
  ) u_burst_addr (
    .addr      (addr_reg),
    .size      (size_reg),
    .len       (len_reg),
    .burst     (burst_reg),
    .next_addr (step_addr)
  );

  // Control and burst context registers; reset drops any burst in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= RD_IDLE;
      arready_reg    <= 1'b0;
      cmd_valid_reg  <= 1'b0;
      id_reg         <= '0;
      addr_reg       <= '0;
      len_reg        <= '0;
      size_reg       <= '0;
      burst_reg      <= '0;
      beats_left_reg <= '0;
    end else begin
      state_reg      <= state_next;
      arready_reg    <= arready_next;
      cmd_valid_reg  <= cmd_valid_next;
      id_reg         <= id_next;
      addr_reg       <= addr_next;
      len_reg        <= len_next;
      size_reg       <= size_next;
      burst_reg      <= burst_next;
      beats_left_reg <= beats_left_next;
    end
  end

  // Next-state: accept an AR in IDLE, then walk the burst one command per handshake
  always_comb begin
    state_next      = state_reg;
    arready_next    = arready_reg;
    cmd_valid_next  = cmd_valid_reg;
    id_next         = id_reg;
    addr_next       = addr_reg;
    len_next        = len_reg;
    size_next       = size_reg;
    burst_next      = burst_reg;
    beats_left_next = beats_left_reg;
    case (state_reg)
      RD_IDLE: begin
        arready_next = 1'b1;
        if (ar_fire) begin
          id_next         = bus.s_axi_arid;
          addr_next       = bus.s_axi_araddr;
          len_next        = bus.s_axi_arlen;
          size_next       = bus.s_axi_arsize;
          burst_next      = bus.s_axi_arburst;
          beats_left_next = bus.s_axi_arlen;
          arready_next    = 1'b0;
          cmd_valid_next  = 1'b1;
          state_next      = RD_BURST;
        end
      end
      RD_BURST: begin
        arready_next = 1'b0;
        if (cmd_fire) begin
          if (last_beat) begin
            cmd_valid_next = 1'b0;
            arready_next   = 1'b1;
            state_next     = RD_IDLE;
          end else begin
            beats_left_next = beats_left_reg - 8'd1;
            addr_next       = step_addr;
          end
        end
      end
      default: begin
        state_next     = RD_IDLE;
        arready_next   = 1'b0;
        cmd_valid_next = 1'b0;
      end
    endcase
  end

  assign bus.s_axi_arready     = arready_reg;
  assign bus.sram_rd_cmd_valid = cmd_valid_reg;
  assign bus.sram_rd_cmd_addr  = addr_reg[AW-1:LSB];
  assign bus.sram_rd_cmd_meta  = {id_reg, last_beat};

  // R channel is a straight pass-through of the SRAM response
  assign bus.s_axi_rvalid       = bus.sram_rd_resp_valid;
  assign bus.sram_rd_resp_ready = bus.s_axi_rready;
  assign bus.s_axi_rdata        = bus.sram_rd_resp_data;
  assign bus.s_axi_rid          = bus.sram_rd_resp_meta[MW-1:1];
  assign bus.s_axi_rlast        = bus.sram_rd_resp_meta[0];
  assign bus.s_axi_rresp        = AXI_RESP_OKAY;

endmodule

// File: tb/tb_svc_axi_sram_if_rd_burst.sv
// Directed bench for svc_axi_sram_if_rd_burst (AW=20, DW=16, IW=4).
// A table of bursts with hand-computed SRAM word addresses is replayed,
// plus hand-written sequences for reset, a stalled single beat, the R path
// and a reset in the middle of a burst.
module tb_svc_axi_sram_if_rd_burst;

  localparam int AW  = 20;
  localparam int DW  = 16;
  localparam int IW  = 4;
  localparam int SAW = 19;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  svc_axi_sram_if_rd_burst_if #(
    .AXI_ADDR_WIDTH(AW),
    .AXI_DATA_WIDTH(DW),
    .AXI_ID_WIDTH  (IW)
  ) bus ();

  svc_axi_sram_if_rd_burst #(
    .AXI_ADDR_WIDTH(AW),
    .AXI_DATA_WIDTH(DW),
    .AXI_ID_WIDTH  (IW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]           id;
    logic [19:0]          addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 stall;
    logic [3:0][SAW-1:0]  exp;
  } vec_t;

  vec_t vecs[6];

  function automatic vec_t mk(input logic [3:0] id, input logic [19:0] addr,
                              input logic [7:0] len, input logic [2:0] size,
                              input logic [1:0] burst, input logic stall,
                              input logic [SAW-1:0] e0, input logic [SAW-1:0] e1,
                              input logic [SAW-1:0] e2, input logic [SAW-1:0] e3);
    vec_t v;
    v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst; v.stall = stall;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for arready, present one AR beat, and check the command appears next cycle
  task automatic send_ar(input logic [3:0] id, input logic [19:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    for (int i = 0; i < 20 && bus.s_axi_arready !== 1'b1; i++) tick();
    check("ar_ready_wait", 32'(bus.s_axi_arready), 32'd1);
    bus.s_axi_arvalid = 1'b1;
    bus.s_axi_arid    = id;
    bus.s_axi_araddr  = addr;
    bus.s_axi_arlen   = len;
    bus.s_axi_arsize  = size;
    bus.s_axi_arburst = burst;
    tick();
    bus.s_axi_arvalid = 1'b0;
    check("ar_ready_low_in_burst", 32'(bus.s_axi_arready), 32'd0);
    check("cmd_valid_after_ar", 32'(bus.sram_rd_cmd_valid), 32'd1);
  endtask

  // Consume n commands, optionally stalling one cycle before each
  task automatic run_beats(input logic [3:0] id, input int n, input logic [3:0][SAW-1:0] exp,
                           input logic stall);
    for (int b = 0; b < n; b++) begin
      if (stall) begin
        bus.sram_rd_cmd_ready = 1'b0;
        check("stall_valid", 32'(bus.sram_rd_cmd_valid), 32'd1);
        check("stall_addr", 32'(bus.sram_rd_cmd_addr), 32'(exp[b]));
        tick();
      end
      bus.sram_rd_cmd_ready = 1'b1;
      check("beat_valid", 32'(bus.sram_rd_cmd_valid), 32'd1);
      check("beat_addr", 32'(bus.sram_rd_cmd_addr), 32'(exp[b]));
      check("beat_meta", 32'(bus.sram_rd_cmd_meta), 32'({id, (b == n - 1)}));
      tick();
    end
    bus.sram_rd_cmd_ready = 1'b0;
    check("end_cmd_valid", 32'(bus.sram_rd_cmd_valid), 32'd0);
    check("end_arready", 32'(bus.s_axi_arready), 32'd1);
  endtask

  // Safety net against a hung DUT
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Main stimulus
  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = mk(4'h1, 20'h00010, 8'd3, 3'd1, 2'b01, 1'b0, 19'h8, 19'h9, 19'hA, 19'hB);
`ifdef SVC_AXI_SRAM_IF_RD_WRAP_EN
    vecs[1] = mk(4'h2, 20'h00014, 8'd3, 3'd1, 2'b10, 1'b0, 19'hA, 19'hB, 19'h8, 19'h9);
    vecs[5] = mk(4'h4, 20'h00003, 8'd1, 3'd0, 2'b10, 1'b1, 19'h1, 19'h1, 19'h0, 19'h0);
`else
    vecs[1] = mk(4'h2, 20'h00014, 8'd3, 3'd1, 2'b10, 1'b0, 19'hA, 19'hB, 19'hC, 19'hD);
    vecs[5] = mk(4'h4, 20'h00003, 8'd1, 3'd0, 2'b10, 1'b1, 19'h1, 19'h2, 19'h0, 19'h0);
`endif
    vecs[2] = mk(4'h5, 20'h00020, 8'd2, 3'd1, 2'b00, 1'b0, 19'h10, 19'h10, 19'h10, 19'h0);
    vecs[3] = mk(4'h7, 20'h00001, 8'd2, 3'd0, 2'b01, 1'b1, 19'h0, 19'h1, 19'h1, 19'h0);
    vecs[4] = mk(4'hF, 20'hFFFFC, 8'd3, 3'd1, 2'b11, 1'b1, 19'h7FFFE, 19'h7FFFF, 19'h0, 19'h1);

    rst_n = 1'b0;
    bus.s_axi_arvalid = 1'b0; bus.s_axi_arid = '0; bus.s_axi_araddr = '0;
    bus.s_axi_arlen = '0; bus.s_axi_arsize = '0; bus.s_axi_arburst = '0;
    bus.s_axi_rready = 1'b0; bus.sram_rd_cmd_ready = 1'b0;
    bus.sram_rd_resp_valid = 1'b0; bus.sram_rd_resp_data = '0; bus.sram_rd_resp_meta = '0;

    // Reset state
    repeat (3) tick();
    check("rst_arready", 32'(bus.s_axi_arready), 32'd0);
    check("rst_cmd_valid", 32'(bus.sram_rd_cmd_valid), 32'd0);
    check("rst_cmd_addr", 32'(bus.sram_rd_cmd_addr), 32'd0);
    check("rst_cmd_meta", 32'(bus.sram_rd_cmd_meta), 32'd1);
    rst_n = 1'b1;
    tick();
    check("post_rst_arready", 32'(bus.s_axi_arready), 32'd1);
    $display("reset sequence done");

    // Single beat held under SRAM backpressure
    send_ar(4'hB, 20'h0A000, 8'd0, 3'd1, 2'b01);
    for (int i = 0; i < 3; i++) begin
      check("single_hold_valid", 32'(bus.sram_rd_cmd_valid), 32'd1);
      check("single_hold_addr", 32'(bus.sram_rd_cmd_addr), 32'h5000);
      check("single_hold_meta", 32'(bus.sram_rd_cmd_meta), 32'h17);
      tick();
    end
    bus.sram_rd_cmd_ready = 1'b1;
    check("single_fire_valid", 32'(bus.sram_rd_cmd_valid), 32'd1);
    tick();
    bus.sram_rd_cmd_ready = 1'b0;
    check("single_done_valid", 32'(bus.sram_rd_cmd_valid), 32'd0);
    check("single_done_arready", 32'(bus.s_axi_arready), 32'd1);
    $display("single-beat burst id=B addr=0xA000 done");

    // Table of bursts
    for (int v = 0; v < 6; v++) begin
      send_ar(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst);
      run_beats(vecs[v].id, int'(vecs[v].len) + 1, vecs[v].exp, vecs[v].stall);
      $display("burst %0d id=%0h addr=0x%05h len=%0d size=%0d type=%0d stall=%0d done",
               v, vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst, vecs[v].stall);
    end

    // R path pass-through with backpressure
    bus.sram_rd_resp_valid = 1'b1;
    bus.sram_rd_resp_meta  = 5'b00111;
    bus.sram_rd_resp_data  = 16'hBEEF;
    bus.s_axi_rready       = 1'b0;
    #1;
    check("r_bp_resp_ready", 32'(bus.sram_rd_resp_ready), 32'd0);
    check("r_bp_rvalid", 32'(bus.s_axi_rvalid), 32'd1);
    bus.s_axi_rready = 1'b1;
    #1;
    check("r_resp_ready", 32'(bus.sram_rd_resp_ready), 32'd1);
    check("r_rid", 32'(bus.s_axi_rid), 32'h3);
    check("r_rlast", 32'(bus.s_axi_rlast), 32'd1);
    check("r_rresp", 32'(bus.s_axi_rresp), 32'd0);
    check("r_rdata", 32'(bus.s_axi_rdata), 32'hBEEF);
    bus.sram_rd_resp_valid = 1'b0;
    bus.sram_rd_resp_meta  = 5'b10100;
    bus.sram_rd_resp_data  = 16'h1234;
    #1;
    check("r_idle_rvalid", 32'(bus.s_axi_rvalid), 32'd0);
    check("r_rid_a", 32'(bus.s_axi_rid), 32'hA);
    check("r_rlast_0", 32'(bus.s_axi_rlast), 32'd0);
    check("r_rdata_2", 32'(bus.s_axi_rdata), 32'h1234);
    bus.s_axi_rready = 1'b0;
    $display("R path pass-through done");

    // Reset during beat 2 of 4, then a clean single-beat burst
    tick();
    send_ar(4'h6, 20'h00040, 8'd3, 3'd1, 2'b01);
    bus.sram_rd_cmd_ready = 1'b1;
    check("mid_beat0_addr", 32'(bus.sram_rd_cmd_addr), 32'h20);
    tick();
    check("mid_beat1_addr", 32'(bus.sram_rd_cmd_addr), 32'h21);
    check("mid_beat1_meta", 32'(bus.sram_rd_cmd_meta), 32'h0C);
    rst_n = 1'b0;
    bus.sram_rd_cmd_ready = 1'b0;
    tick();
    check("mid_rst_cmd_valid", 32'(bus.sram_rd_cmd_valid), 32'd0);
    check("mid_rst_arready", 32'(bus.s_axi_arready), 32'd0);
    rst_n = 1'b1;
    tick();
    check("mid_post_arready", 32'(bus.s_axi_arready), 32'd1);
    check("mid_post_cmd_valid", 32'(bus.sram_rd_cmd_valid), 32'd0);
    send_ar(4'h9, 20'h00100, 8'd0, 3'd1, 2'b01);
    check("clean_addr", 32'(bus.sram_rd_cmd_addr), 32'h80);
    check("clean_meta", 32'(bus.sram_rd_cmd_meta), 32'h13);
    bus.sram_rd_cmd_ready = 1'b1;
    tick();
    bus.sram_rd_cmd_ready = 1'b0;
    check("clean_done_valid", 32'(bus.sram_rd_cmd_valid), 32'd0);
    check("clean_done_arready", 32'(bus.s_axi_arready), 32'd1);
    $display("mid-burst reset and recovery done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
